// File: rtl/key_entry_pkg.sv
// Shared key codes and FSM state type for the keypad entry block.
package key_entry_pkg;

    localparam logic [4:0] KEY_DIGIT_MAX = 5'd15;
    localparam logic [4:0] KEY_ENTER     = 5'd16;
    localparam logic [4:0] KEY_BKSP      = 5'd17;
    localparam logic [4:0] KEY_CLEAR     = 5'd18;
    localparam logic [4:0] KEY_NEG       = 5'd19;

    typedef enum logic {
        S_IDLE,
        S_HOLD
    } state_e;

    function automatic logic is_digit(input logic [4:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/key_edge_filter.sv
// Turns the raw key strobe into a one-cycle press pulse; optional holdoff
// window when KEY_ENTRY_DEBOUNCE_EN is defined.
module key_edge_filter #(
    parameter int unsigned HOLDOFF = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keystrobe_i,
    input  logic [4:0] keycode_i,
    output logic       press_o,
    output logic [4:0] code_o
);

    logic strobe_q;
    logic edge_w;

    assign edge_w = keystrobe_i & ~strobe_q;
    assign code_o = keycode_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) strobe_q <= 1'b0;
        else      strobe_q <= keystrobe_i;
    end

`ifdef KEY_ENTRY_DEBOUNCE_EN
    localparam int unsigned HW = $clog2(HOLDOFF + 1);

    logic [HW-1:0] holdoff_q;

    // strobe_q keeps tracking during the window, so a press held across its end is not accepted late
    assign press_o = edge_w && (holdoff_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 holdoff_q <= '0;
        else if (press_o)         holdoff_q <= HW'(HOLDOFF);
        else if (holdoff_q != '0) holdoff_q <= holdoff_q - 1'b1;
    end
`else
    logic [31:0] unused_holdoff;

    assign unused_holdoff = HOLDOFF;
    assign press_o        = edge_w;
`endif

endmodule

// File: rtl/key_entry.sv
// Keypad hex-entry editor with sign toggle and valid/ready output.
// Define KEY_ENTRY_DEBOUNCE_EN to enable the press holdoff window.
module key_entry
    import key_entry_pkg::*;
#(
    parameter int unsigned DIGITS  = 8,
    parameter int unsigned HOLDOFF = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [4:0]                   keycode,
    input  logic                         keystrobe,
    output logic [4*DIGITS-1:0]          disp_o,
    output logic [$clog2(DIGITS+1)-1:0]  count_o,
    output logic                         neg_o,
    output logic                         ovf_o,
    output logic [4*DIGITS-1:0]          data_o,
    output logic                         data_valid,
    input  logic                         data_ready
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);

    logic          press_w;
    logic [4:0]    code_w;
    state_e        state_q;
    logic [W-1:0]  edit_q;
    logic [CW-1:0] count_q;
    logic          neg_q;
    logic          ovf_q;
    logic [W-1:0]  data_q;
    logic          valid_q;
    logic [W-1:0]  value_d;

    key_edge_filter #(
        .HOLDOFF(HOLDOFF)
    ) u_filter (
        .clk        (clk),
        .rst        (rst),
        .keystrobe_i(keystrobe),
        .keycode_i  (keycode),
        .press_o    (press_w),
        .code_o     (code_w)
    );

    assign value_d = neg_q ? ('0 - edit_q) : edit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            edit_q  <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (press_w) begin
                        if (is_digit(code_w)) begin
                            if (count_q < CW'(DIGITS)) begin
                                edit_q  <= {edit_q[W-5:0], code_w[3:0]};
                                count_q <= count_q + 1'b1;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else begin
                            case (code_w)
                                KEY_ENTER: begin
                                    if (count_q != '0) begin
                                        data_q  <= value_d;
                                        valid_q <= 1'b1;
                                        state_q <= S_HOLD;
                                    end
                                end
                                KEY_BKSP: begin
                                    if (count_q != '0) begin
                                        edit_q  <= edit_q >> 4;
                                        count_q <= count_q - 1'b1;
                                    end
                                end
                                KEY_CLEAR: begin
                                    edit_q  <= '0;
                                    count_q <= '0;
                                    neg_q   <= 1'b0;
                                    ovf_q   <= 1'b0;
                                end
                                KEY_NEG: neg_q <= ~neg_q;
                                default: ;
                            endcase
                        end
                    end
                end
                S_HOLD: begin
                    // abort via CLEAR and handshake completion leave identical state
                    if ((press_w && code_w == KEY_CLEAR) || data_ready) begin
                        edit_q  <= '0;
                        count_q <= '0;
                        neg_q   <= 1'b0;
                        ovf_q   <= 1'b0;
                        valid_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign disp_o     = edit_q;
    assign count_o    = count_q;
    assign neg_o      = neg_q;
    assign ovf_o      = ovf_q;
    assign data_o     = data_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed editing scenarios plus random
// key traffic compared against a digit-queue reference model.
module tb_key_entry;
    import key_entry_pkg::*;

    localparam int unsigned DIGITS  = 8;
    localparam int unsigned HOLDOFF = 16;
    localparam int unsigned W       = 4 * DIGITS;
`ifdef KEY_ENTRY_DEBOUNCE_EN
    localparam int unsigned PGAP = HOLDOFF + 1;
`else
    localparam int unsigned PGAP = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [4:0]    keycode = '0;
    logic          keystrobe = 1'b0;
    logic          data_ready = 1'b0;
    logic [W-1:0]  disp_o;
    logic [3:0]    count_o;
    logic          neg_o;
    logic          ovf_o;
    logic [W-1:0]  data_o;
    logic          data_valid;

    key_entry #(
        .DIGITS (DIGITS),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .keycode   (keycode),
        .keystrobe (keystrobe),
        .disp_o    (disp_o),
        .count_o   (count_o),
        .neg_o     (neg_o),
        .ovf_o     (ovf_o),
        .data_o    (data_o),
        .data_valid(data_valid),
        .data_ready(data_ready)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // reference model: the buffer is an ordered list of entered digits
    int                m_digits[$];
    bit                m_neg, m_ovf, m_hold, m_prev;
    longint unsigned   m_data;
    int                m_hold_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint unsigned m_mag();
        longint unsigned v = 0;
        foreach (m_digits[i]) v = v * 16 + longint'(m_digits[i]);
        return v;
    endfunction

    function automatic longint unsigned m_signed();
        longint unsigned mag = m_mag();
        if (m_neg) return (64'h1_0000_0000 - mag) & 64'hFFFF_FFFF;
        return mag;
    endfunction

    function automatic void model_clear();
        m_digits.delete();
        m_neg = 0;
        m_ovf = 0;
    endfunction

    function automatic void model_reset();
        model_clear();
        m_hold = 0;
        m_prev = 0;
        m_data = 0;
        m_hold_cnt = 0;
    endfunction

    function automatic void model_edge(input logic strobe, input logic [4:0] code, input logic ready);
        bit acc;
        acc = strobe && !m_prev;
        m_prev = strobe;
`ifdef KEY_ENTRY_DEBOUNCE_EN
        if (m_hold_cnt != 0) begin
            acc = 0;
            m_hold_cnt--;
        end else if (acc) begin
            m_hold_cnt = HOLDOFF;
        end
`endif
        if (m_hold) begin
            if ((acc && code == 5'd18) || ready) begin
                model_clear();
                m_hold = 0;
            end
        end else if (acc) begin
            if (code < 16) begin
                if (m_digits.size() < DIGITS) m_digits.push_back(int'(code));
                else m_ovf = 1;
            end else if (code == 5'd16) begin
                if (m_digits.size() > 0) begin
                    m_data = m_signed();
                    m_hold = 1;
                end
            end else if (code == 5'd17) begin
                if (m_digits.size() > 0) void'(m_digits.pop_back());
            end else if (code == 5'd18) begin
                model_clear();
            end else if (code == 5'd19) begin
                m_neg = !m_neg;
            end
        end
    endfunction

    task automatic compare_all();
        check("disp",  64'(disp_o),     m_mag());
        check("count", 64'(count_o),    64'(m_digits.size()));
        check("neg",   64'(neg_o),      64'(m_neg));
        check("ovf",   64'(ovf_o),      64'(m_ovf));
        check("valid", 64'(data_valid), 64'(m_hold));
        check("data",  64'(data_o),     m_data);
    endtask

    task automatic step(input logic strobe, input logic [4:0] code, input logic ready);
        keystrobe  = strobe;
        keycode    = code;
        data_ready = ready;
        @(posedge clk);
        model_edge(strobe, code, ready);
        @(negedge clk);
        compare_all();
    endtask

    task automatic press(input logic [4:0] code, input logic ready);
        step(1'b1, code, ready);
        repeat (PGAP) step(1'b0, code, ready);
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_disp",  64'(disp_o),     64'h0);
        check("rst_valid", 64'(data_valid), 64'h0);
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // 1, 2, A, ENTER with consumer stalled
        press(5'd1, 0); press(5'd2, 0); press(5'hA, 0); press(KEY_ENTER, 0);
        check("e1_disp",  64'(disp_o),     64'h12A);
        check("e1_count", 64'(count_o),    64'd3);
        check("e1_valid", 64'(data_valid), 64'h1);
        check("e1_data",  64'(data_o),     64'h12A);
        repeat (3) step(1'b0, 5'd0, 1'b0);
        check("e1_held",  64'(data_o),     64'h12A);
        step(1'b0, 5'd0, 1'b1);
        check("e1_drop",  64'(data_valid), 64'h0);
        check("e1_clr",   64'(count_o),    64'h0);

        // negative entry with ready permanently high
        press(KEY_NEG, 1); press(5'd5, 1);
        step(1'b1, KEY_ENTER, 1'b1);
        check("neg_data",  64'(data_o),     64'hFFFF_FFFB);
        check("neg_valid", 64'(data_valid), 64'h1);
        step(1'b0, 5'd0, 1'b1);
        check("neg_pulse", 64'(data_valid), 64'h0);
        repeat (PGAP) step(1'b0, 5'd0, 1'b0);

        // overflow then backspace then clear
        for (int d = 1; d <= 9; d++) press(5'(d), 0);
        check("ovf_disp", 64'(disp_o), 64'h1234_5678);
        check("ovf_flag", 64'(ovf_o),  64'h1);
        press(KEY_BKSP, 0);
        check("bk_disp",  64'(disp_o),  64'h0123_4567);
        check("bk_count", 64'(count_o), 64'd7);
        check("bk_ovf",   64'(ovf_o),   64'h1);
        press(KEY_CLEAR, 0);
        check("clr_disp", 64'(disp_o), 64'h0);
        check("clr_ovf",  64'(ovf_o),  64'h0);

        // no-op keys on an empty buffer
        press(KEY_ENTER, 0); press(KEY_BKSP, 0); press(5'd25, 0);
        check("nop_valid", 64'(data_valid), 64'h0);
        check("nop_count", 64'(count_o),    64'h0);

        // HOLD ignores digits, CLEAR aborts
        press(5'd3, 0); press(KEY_ENTER, 0); press(5'd7, 0);
        check("hold_disp",  64'(disp_o),     64'h3);
        check("hold_valid", 64'(data_valid), 64'h1);
        press(KEY_CLEAR, 0);
        check("abort_valid", 64'(data_valid), 64'h0);
        check("abort_disp",  64'(disp_o),     64'h0);

        // asynchronous reset while holding
        press(5'd4, 0); press(KEY_ENTER, 0);
        check("pre_rst_valid", 64'(data_valid), 64'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_valid", 64'(data_valid), 64'h0);
        check("arst_data",  64'(data_o),     64'h0);
        model_reset();
        compare_all();
        @(negedge clk);
        rst = 1'b1;

        // edges 5 and 20 cycles after the first press
        step(1'b1, 5'd1, 1'b0);
        repeat (4) step(1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd2, 1'b0);
        repeat (14) step(1'b0, 5'd0, 1'b0);
        step(1'b1, 5'd3, 1'b0);
        step(1'b0, 5'd0, 1'b0);
`ifdef KEY_ENTRY_DEBOUNCE_EN
        check("db_count", 64'(count_o), 64'd2);
        check("db_disp",  64'(disp_o),  64'h13);
`else
        check("db_count", 64'(count_o), 64'd3);
        check("db_disp",  64'(disp_o),  64'h123);
`endif
        repeat (HOLDOFF + 1) step(1'b0, 5'd0, 1'b0);
        press(KEY_CLEAR, 0);

        // random key traffic
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] c;
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r <= 5)      c = 5'($urandom_range(0, 15));
            else if (r == 6) c = KEY_ENTER;
            else if (r == 7) c = KEY_BKSP;
            else if (r == 8) c = ($urandom_range(0, 2) == 0) ? KEY_CLEAR : KEY_NEG;
            else             c = 5'($urandom_range(16, 31));
            step(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/key_entry.md
# key_entry

Keypad input reader for the single-cycle core's I/O space. Consumes the 5-bit key code and key strobe produced by the keypad encoder, edge-detects each key press, and assembles hex digits into a signed value with backspace, clear and sign-toggle editing. On ENTER it presents the value to the bus side through a valid/ready handshake and holds it until accepted.

## Interface
- DIGITS, 8: max hex digits held; value width W = 4*DIGITS.
- HOLDOFF, 16: cycles after an accepted press during which new strobe edges are dropped (debounce build only).
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- keycode  input  5  key code; valid whenever keystrobe is high.
- keystrobe  input  1  high while a key is held; registered in clk domain.
- disp_o  output  W  current edit buffer, unsigned magnitude.
- count_o  output  $clog2(DIGITS+1)  digits currently in buffer.
- neg_o  output  1  sign flag of the value being edited.
- ovf_o  output  1  sticky: a digit was pressed with the buffer full.
- data_o  output  W  entered value, two's complement (neg ? -buf : buf), mod 2^W.
- data_valid  output  1  data_o is valid.
- data_ready  input  1  consumer accepts data_o.

## Operation
- Press = rising edge of keystrobe (keystrobe & ~strobe_q). keycode sampled in the same cycle as the edge.
- Code map: 0-15 hex digit; 16 ENTER; 17 BACKSPACE; 18 CLEAR; 19 NEG; 20-31 ignored (no state change).
- States: IDLE (editing), HOLD (data_valid high).
- IDLE, digit: count < DIGITS -> buf = (buf << 4) | code, count+1; else buf unchanged, ovf_o <= 1.
- IDLE, BACKSPACE: count > 0 -> buf >> 4, count-1; count == 0 -> no change.
- IDLE, CLEAR: buf, count, neg, ovf all to 0.
- IDLE, NEG: neg toggles (allowed with count == 0).
- IDLE, ENTER: count == 0 -> ignored; else data_o <= signed value, data_valid <= 1, go HOLD.
- HOLD: all presses dropped except CLEAR, which drops data_valid, clears buf/count/neg/ovf, returns to IDLE (abort).
- HOLD, data_valid & data_ready at a clock edge: data_valid <= 0, buf/count/neg/ovf cleared, go IDLE.
- Key released and re-pressed = two presses; a held key repeats nothing.

## Timing
- Reset: disp_o 0, count_o 0, neg_o 0, ovf_o 0, data_o 0, data_valid 0, state IDLE, strobe_q 0, holdoff counter 0. Reset mid-HOLD drops data_valid immediately (async).
- Press latency: edge seen at clock edge N -> disp_o/count_o/neg_o/ovf_o/data_valid updated after edge N (visible cycle N+1).
- data_o and data_valid stable from assertion until handshake; data_ready may be held high permanently (data_valid then lasts exactly 1 cycle).
- Press edge in the same cycle as handshake completion: press dropped (state is HOLD at that edge).
- CLEAR edge in same cycle as handshake: single clear; result identical.
- data_o arithmetic: negate is W-bit two's complement; buf = 0 with neg gives 0.

## Configuration
- KEY_ENTRY_DEBOUNCE_EN defined: accepted press loads holdoff counter with HOLDOFF; while counter != 0 it decrements each cycle and rising edges are dropped (strobe_q still tracks keystrobe, so a press spanning the window end is not accepted late).
- Undefined: no counter; every rising edge is a press; HOLDOFF unused.

## Structure
- key_entry_pkg: key code constants (KEY_ENTER 16, KEY_BKSP 17, KEY_CLEAR 18, KEY_NEG 19, KEY_DIGIT_MAX 15), state enum (S_IDLE, S_HOLD).
- Sub-module key_edge_filter: strobe register, edge detect, optional holdoff counter; outputs 1-cycle press pulse and sampled code.
- key_entry: edit buffer, FSM, negation, handshake.

## Test plan
- Press 1, 2, A, ENTER with data_ready low -> disp_o 0x12A, count_o 3, data_valid high, data_o 0x0000012A held; raise data_ready -> valid drops next cycle, disp_o 0, count_o 0.
- Press NEG, 5, ENTER, data_ready high -> data_o 0xFFFFFFFB, data_valid high exactly 1 cycle.
- Press 9 digits 1..9 -> disp_o 0x12345678, ovf_o 1; BACKSPACE -> 0x01234567, count 7, ovf_o still 1; CLEAR -> all 0.
- ENTER with count 0, BACKSPACE with count 0, code 25 -> no output change, data_valid stays 0.
- In HOLD press 7 -> ignored; press CLEAR -> data_valid 0, buffer 0; assert rst low mid-HOLD -> all outputs 0 asynchronously.
- Debounce build: two strobe edges 5 cycles apart with HOLDOFF 16 -> only first counted; edge at 20 cycles -> counted. Non-debounce build: both counted.
